// File: rtl/jesd204_pkg.sv
// Shared constants and types for the JESD204 transmit lane path.
package jesd204_pkg;

  // 8b/10b control characters used by the link layer
  localparam logic [7:0] CharK28_5 = 8'hBC; // /K/ code-group synchronisation
  localparam logic [7:0] CharK28_3 = 8'h7C; // /A/ end of multiframe
  localparam logic [7:0] CharK28_7 = 8'hFC; // /F/ end of frame
  localparam logic [7:0] CharR     = 8'h1C; // /R/ start of multiframe
  localparam logic [7:0] CharQ     = 8'h9C; // /Q/ start of ILAS config data

  // Scrambler state while no user data is flowing
  localparam logic [14:0] ScramblerSeed = 15'h7F80;

  // Per-beat source selection for the lane
  typedef enum logic [1:0] {
    SrcCgs,
    SrcData,
    SrcIlas
  } tx_src_e;

  // Octet n of a beat, octet 0 in the low bits
  function automatic logic [7:0] get_octet(input logic [31:0] beat, input int unsigned idx);
    return beat[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/jesd204_scrambler.sv
// Self-synchronous 1+x^14+x^15 scrambler, octet 0 first and MSB first within an octet.
// Output is combinational for the current beat; the state register holds the last 15
// scrambled bits, bit 0 being the most recent.
module jesd204_scrambler
  import jesd204_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic             bypass_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [14:0]      state_q;
  logic [14:0]      state_d;
  logic [WIDTH-1:0] scrambled;

  // Walk the beat bit by bit in serial order, feeding each output bit back into the state
  always_comb begin
    logic [14:0] st;
    logic        nb;
    st        = state_q;
    nb        = 1'b0;
    scrambled = '0;
    for (int o = 0; o < int'(WIDTH / 8); o++) begin
      for (int b = 7; b >= 0; b--) begin
        nb                 = data_i[o*8 + b] ^ st[13] ^ st[14];
        scrambled[o*8 + b] = nb;
        st                 = {st[13:0], nb};
      end
    end
    state_d = st;
    data_o  = bypass_i ? data_i : scrambled;
  end

  // State reloads to the seed outside data mode and advances one beat per data beat
  always_ff @(posedge clk_i) begin
    if (reset_i || load_i) begin
      state_q <= ScramblerSeed;
    end else if (enable_i) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/jesd204_tx_lane_mux.sv
// JESD204 transmit lane multiplexer: selects CGS, ILAS or scrambled user data per beat,
// applies end-of-frame / end-of-multiframe character replacement, and registers the
// result towards the PHY with one cycle of latency.
module jesd204_tx_lane_mux
  import jesd204_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cgs_enable,
  input  logic                         tx_ready,
  input  logic [DATA_PATH_WIDTH*8-1:0] ilas_data,
  input  logic [DATA_PATH_WIDTH-1:0]   ilas_charisk,
  input  logic [DATA_PATH_WIDTH*8-1:0] tx_data,
  input  logic [DATA_PATH_WIDTH-1:0]   eof,
  input  logic [DATA_PATH_WIDTH-1:0]   eomf,
  input  logic                         cfg_disable_scrambler,
  input  logic                         cfg_disable_char_replacement,
  output logic [DATA_PATH_WIDTH*8-1:0] phy_data,
  output logic [DATA_PATH_WIDTH-1:0]   phy_charisk
);

  localparam int unsigned W = DATA_PATH_WIDTH * 8;

  tx_src_e        src;
  logic           data_mode;
  logic [W-1:0]   scr_data;
  logic [W-1:0]   rep_data;
  logic [DATA_PATH_WIDTH-1:0] rep_charisk;

  // Last original octet of the most recent completed frame, for unscrambled replacement
  logic [7:0]     prev_octet_q;
  logic [7:0]     prev_octet_d;
  logic           prev_valid_q;
  logic           prev_valid_d;

  logic [W-1:0]   phy_data_q;
  logic [DATA_PATH_WIDTH-1:0] phy_charisk_q;

  assign data_mode = tx_ready & ~cgs_enable;

  // Source priority: CGS over user data over ILAS
  always_comb begin
    src = SrcIlas;
    if (cgs_enable) begin
      src = SrcCgs;
    end else if (tx_ready) begin
      src = SrcData;
    end
  end

  jesd204_scrambler #(
    .WIDTH (W)
  ) u_scrambler (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (~data_mode),
    .enable_i (data_mode),
    .bypass_i (cfg_disable_scrambler),
    .data_i   (tx_data),
    .data_o   (scr_data)
  );

  // Character replacement; the frame-tail tracker always follows the original data
  always_comb begin
    logic [7:0] oct;
    logic [7:0] orig;
    logic [7:0] last;
    logic       last_valid;
    rep_data    = scr_data;
    rep_charisk = '0;
    last        = prev_octet_q;
    last_valid  = prev_valid_q;
    oct         = 8'h00;
    orig        = 8'h00;
    for (int i = 0; i < int'(DATA_PATH_WIDTH); i++) begin
      oct  = scr_data[i*8 +: 8];
      orig = get_octet(tx_data, i);
      if (!cfg_disable_char_replacement) begin
        if (!cfg_disable_scrambler) begin
          // Scrambled: a scrambled octet that happens to equal /A/ or /F/ is sent as K
          if (eomf[i] && oct == CharK28_3) begin
            rep_charisk[i] = 1'b1;
          end else if (eof[i] && oct == CharK28_7) begin
            rep_charisk[i] = 1'b1;
          end
        end else if (last_valid && orig == last) begin
          // Unscrambled: repeat of the previous frame's last octet is replaced
          if (eomf[i]) begin
            rep_data[i*8 +: 8] = CharK28_3;
            rep_charisk[i]     = 1'b1;
          end else if (eof[i]) begin
            rep_data[i*8 +: 8] = CharK28_7;
            rep_charisk[i]     = 1'b1;
          end
        end
      end
      if (eof[i]) begin
        last       = orig;
        last_valid = 1'b1;
      end
    end

    // Tracker only moves in data mode and is wiped whenever user data stops
    prev_octet_d = prev_octet_q;
    prev_valid_d = prev_valid_q;
    if (!tx_ready) begin
      prev_octet_d = 8'h00;
      prev_valid_d = 1'b0;
    end else if (data_mode) begin
      prev_octet_d = last;
      prev_valid_d = last_valid;
    end
  end

  // Frame-tail tracker state
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_octet_q <= 8'h00;
      prev_valid_q <= 1'b0;
    end else begin
      prev_octet_q <= prev_octet_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Single output register for every source keeps the latency uniform
  always_ff @(posedge clk) begin
    if (reset) begin
      phy_data_q    <= {DATA_PATH_WIDTH{CharK28_5}};
      phy_charisk_q <= '1;
    end else begin
      unique case (src)
        SrcCgs: begin
          phy_data_q    <= {DATA_PATH_WIDTH{CharK28_5}};
          phy_charisk_q <= '1;
        end
        SrcData: begin
          phy_data_q    <= rep_data;
          phy_charisk_q <= rep_charisk;
        end
        default: begin
          phy_data_q    <= ilas_data;
          phy_charisk_q <= ilas_charisk;
        end
      endcase
    end
  end

  assign phy_data    = phy_data_q;
  assign phy_charisk = phy_charisk_q;

endmodule

// File: doc/jesd204_tx_lane_mux.md
JESD204_TX_LANE_MUX -- requirements
Module: jesd204_tx_lane_mux

Interface
REQ-001 SHALL have parameter DATA_PATH_WIDTH, default 4, octets per beat; only 4 is supported.
REQ-002 SHALL have port clk, input, 1, sole clock.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port cgs_enable, input, 1, this lane transmits /K/.
REQ-005 SHALL have port tx_ready, input, 1, this lane transmits user data.
REQ-006 SHALL have port ilas_data, input, 32, ILAS octets from the link controller.
REQ-007 SHALL have port ilas_charisk, input, 4, ILAS K flags from the link controller.
REQ-008 SHALL have port tx_data, input, 32, user octets; octet 0 is in bits [7:0].
REQ-009 SHALL have port eof, input, 4, per-octet end-of-frame marker.
REQ-010 SHALL have port eomf, input, 4, per-octet end-of-multiframe marker.
REQ-011 SHALL have port cfg_disable_scrambler, input, 1, static configuration.
REQ-012 SHALL have port cfg_disable_char_replacement, input, 1, static configuration.
REQ-013 SHALL have port phy_data, output, 32, octets to the PHY.
REQ-014 SHALL have port phy_charisk, output, 4, K flags to the PHY.

Function
REQ-015 SHALL select the source per beat with priority cgs_enable > tx_ready > ILAS.
- CGS: all four octets 8'hBC, charisk 4'hF.
- ILAS: ilas_data and ilas_charisk passed unchanged.
- Data: scrambled and character-replaced tx_data.
REQ-016 SHALL register outputs once, giving a fixed latency of 1 cycle from inputs to phy_data/phy_charisk for every source.
REQ-017 SHALL scramble with polynomial 1+x^14+x^15 (self-synchronous, serial octet order 0..3, bit 7 first); an output bit is the data bit XOR S14 XOR S15 of prior scrambled output bits.
REQ-018 SHALL hold the scrambler state at 15'h7F80 whenever tx_ready=0 or cgs_enable=1, and advance it 32 bits per data beat.
REQ-019 SHALL pass data unscrambled when cfg_disable_scrambler=1; the state still reloads per REQ-018.
REQ-020 SHALL apply character replacement in data mode only, and only when cfg_disable_char_replacement=0.
REQ-021 Character replacement with scrambling on SHALL use the scrambled octet:
- eomf and octet==8'h7C: send K28.3 (8'h7C, K=1).
- else eof and octet==8'hFC: send K28.7 (8'hFC, K=1).
REQ-022 Character replacement with scrambling off SHALL compare the octet with the last octet of the previous frame; on a match, eomf gives K28.3 (8'h7C), else eof gives K28.7 (8'hFC).
REQ-023 "Previous frame last octet" SHALL be the nearest lower-index eof octet in the same beat, otherwise the stored value from an earlier beat; it SHALL always be the original, unreplaced data.
REQ-024 SHALL keep a prev_valid flag:
- cleared while tx_ready=0;
- set by the first eof octet in data mode.
- No unscrambled replacement occurs while prev_valid=0; this covers the first frame after data start.
REQ-025 Data octets that are not replaced SHALL carry charisk 0.
REQ-026 eof/eomf SHALL be ignored outside data mode.
REQ-027 A tx_ready 1->0 mid-frame SHALL switch the source on the next output beat and reset the scrambler and prev_valid with no residual state.

Reset
REQ-028 While reset=1, outputs SHALL be phy_data=32'hBCBCBCBC and phy_charisk=4'hF (CGS); the scrambler SHALL be at 15'h7F80, prev_valid=0 and the stored octet=8'h00.
REQ-029 The first output beat after reset deasserts SHALL reflect the inputs per REQ-015 with latency per REQ-016.

Structure
REQ-030 A shared package (jesd204_pkg) SHALL hold the control-character constants (K28.5 8'hBC, K28.3 8'h7C, K28.7 8'hFC, /R/ 8'h1C, /Q/ 8'h9C) and the scrambler seed 15'h7F80.
REQ-031 The scrambler SHALL be a separate sub-module, jesd204_scrambler, parameterised by width, with a 15-bit state, a load/enable input and bypass.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- cgs_enable=1, tx_ready=1, tx_data=32'h12345678 -> next cycle phy_data=32'hBCBCBCBC, charisk=4'hF.
- cgs=0, tx_ready=0, ilas_data=32'h7C00011C, ilas_charisk=4'b1001 -> passed unchanged 1 cycle later.
- Scrambler off, F=4 (eof=4'b1000), two beats 32'hAA000000 with eomf=0 -> second beat octet 3 = 8'hFC K=1, first beat unreplaced.
- Same as above with eomf=4'b1000 on the second beat -> octet 3 = 8'h7C K=1; cfg_disable_char_replacement=1 -> 8'hAA K=0.
- Scrambler on, all-zero tx_data after tx_ready rises -> phy_data matches the reference LFSR model seeded 15'h7F80; no K flags unless the scrambled eof octet is 8'hFC.
- Synchronous reset mid-data -> next cycle CGS output; after release, scrambled data restarts from the seed, bit-exact to the first run.
